core_inst_seq: RTL and testbench

//  Instruction sequencer that drives core's 17-bit inst bus and mem_in, replacing the bench-driven stimulus.
//  One start pulse runs a full attention tile:

---
 rtl/core_inst_seq_if.sv | 29 ++
 rtl/core_inst_seq.sv | 143 ++++++++++++++
 tb/tb_core_inst_seq.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/core_inst_seq_if.sv
// Sequencer <-> environment bundle: upstream row stream, core inst/mem_in bus, status.
// master = sequencer side, slave = upstream/core side.
interface core_inst_seq_if #(
  parameter int unsigned bw = 8,
  parameter int unsigned pr = 8
);
  localparam int unsigned DW = pr * bw;

  logic          start;
  logic [3:0]    q_rows_m1;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          fifo_valid;
  logic [DW-1:0] mem_in;
  logic [16:0]   inst;
  logic          busy;
  logic          done;

  modport master (
    input  start, q_rows_m1, in_data, in_valid, fifo_valid,
    output in_ready, mem_in, inst, busy, done
  );

  modport slave (
    output start, q_rows_m1, in_data, in_valid, fifo_valid,
    input  in_ready, mem_in, inst, busy, done
  );
endinterface

// File: rtl/core_inst_seq.sv
// Attention-tile instruction sequencer: loads Q and K rows, feeds K, streams Q,
// then drains the core ofifo into psum memory, all from one start pulse.
module core_inst_seq #(
  parameter int unsigned bw  = 8,
  parameter int unsigned pr  = 8,
  parameter int unsigned col = 8
) (
  input  logic            clk,
  input  logic            reset,
  core_inst_seq_if.master bus
);

  localparam int unsigned DW = pr * bw;
  localparam int unsigned CW = 5;

  localparam int unsigned B_OFR = 16;
  localparam int unsigned B_EX  = 7;
  localparam int unsigned B_KLD = 6;
  localparam int unsigned B_QRD = 5;
  localparam int unsigned B_QWR = 4;
  localparam int unsigned B_KRD = 3;
  localparam int unsigned B_KWR = 2;
  localparam int unsigned B_PWR = 0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_QLOAD = 3'd1,
    S_KLOAD = 3'd2,
    S_KFEED = 3'd3,
    S_EXEC  = 3'd4,
    S_DRAIN = 3'd5,
    S_FIN   = 3'd6
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [3:0]      nq_m1;
  logic [16:0]     inst_q;
  logic [DW-1:0]   mem_q;
  logic            done_q;

  // Status decoded from the state register only; no path from inputs.
  assign bus.in_ready = (state == S_QLOAD) || (state == S_KLOAD);
  assign bus.busy     = (state != S_IDLE);
  assign bus.inst     = inst_q;
  assign bus.mem_in   = mem_q;
  assign bus.done     = done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      nq_m1  <= '0;
      inst_q <= '0;
      mem_q  <= '0;
      done_q <= 1'b0;
    end else begin
      inst_q <= '0;
      done_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            nq_m1 <= bus.q_rows_m1;
            cnt   <= '0;
            state <= S_QLOAD;
          end
        end
        S_QLOAD: begin
          if (bus.in_valid) begin
            inst_q[B_QWR]  <= 1'b1;
            inst_q[15:12]  <= cnt[3:0];
            mem_q          <= bus.in_data;
            if (cnt[3:0] == nq_m1) begin
              cnt   <= '0;
              state <= S_KLOAD;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        S_KLOAD: begin
          if (bus.in_valid) begin
            inst_q[B_KWR]  <= 1'b1;
            inst_q[15:12]  <= cnt[3:0];
            mem_q          <= bus.in_data;
            if (cnt == CW'(col - 1)) begin
              cnt   <= '0;
              state <= S_KFEED;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        S_KFEED: begin
          // Kernel load trails the K read by the SRAM's one-cycle latency.
          inst_q[B_KLD] <= inst_q[B_KRD];
          if (cnt < CW'(col)) begin
            inst_q[B_KRD] <= 1'b1;
            inst_q[15:12] <= cnt[3:0];
          end
          if (cnt == CW'(col)) begin
            cnt   <= '0;
            state <= S_EXEC;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_EXEC: begin
          inst_q[B_EX] <= inst_q[B_QRD];
          if (cnt <= CW'(nq_m1)) begin
            inst_q[B_QRD] <= 1'b1;
            inst_q[15:12] <= cnt[3:0];
          end
          if (cnt == CW'(nq_m1) + CW'(1)) begin
            cnt   <= '0;
            state <= S_DRAIN;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DRAIN: begin
          if (bus.fifo_valid) begin
            inst_q[B_OFR] <= 1'b1;
            inst_q[B_PWR] <= 1'b1;
            inst_q[11:8]  <= cnt[3:0];
            if (cnt[3:0] == nq_m1) begin
              cnt   <= '0;
              state <= S_FIN;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        S_FIN: begin
          done_q <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_inst_seq.sv
// Directed bench for core_inst_seq: cycle-exact inst/mem_in/status checks over
// full tiles, handshake gaps, stalled drain, max row count and mid-run reset.
module tb_core_inst_seq;

  localparam int unsigned BW  = 8;
  localparam int unsigned PR  = 8;
  localparam int unsigned COL = 8;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  core_inst_seq_if #(.bw(BW), .pr(PR)) bus ();

  core_inst_seq #(.bw(BW), .pr(PR), .col(COL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected inst word from individual field values.
  function automatic logic [16:0] iw(input bit ofr, input int qk, input int pm, input bit ex,
                                     input bit kl, input bit qrd, input bit qwr, input bit krd,
                                     input bit kwr, input bit pwr);
    return {ofr, 4'(qk), 4'(pm), ex, kl, qrd, qwr, krd, kwr, 1'b0, pwr};
  endfunction

  function automatic logic [63:0] row(input int t, input int i);
    return {32'(t * 32'h1111_0000 + 32'h00C0_FFEE), 32'(i * 32'h0101_0101 + 7)};
  endfunction

  task automatic run_tile(input int m1, input bit toggle, input int fdelay);
    int nq;
    nq = m1 + 1;
    @(negedge clk);
    bus.start = 1'b1; bus.q_rows_m1 = 4'(m1); bus.in_valid = 1'b0; bus.fifo_valid = 1'b0;
    @(negedge clk);
    bus.start = 1'b0; bus.q_rows_m1 = 4'd0;
    chk("start_busy", 64'(bus.busy), 1);
    chk("start_ready", 64'(bus.in_ready), 1);
    chk("start_inst", 64'(bus.inst), 0);
    for (int i = 0; i < nq; i++) begin
      bus.in_valid = 1'b1; bus.in_data = row(1, i);
      @(negedge clk);
      chk($sformatf("qwr_inst%0d", i), 64'(bus.inst), 64'(iw(0, i, 0, 0, 0, 0, 1, 0, 0, 0)));
      chk($sformatf("qwr_mem%0d", i), bus.mem_in, row(1, i));
      if (toggle) begin
        bus.in_valid = 1'b0; bus.in_data = row(9, i);
        @(negedge clk);
        chk($sformatf("qgap_inst%0d", i), 64'(bus.inst), 0);
        chk($sformatf("qgap_mem%0d", i), bus.mem_in, row(1, i));
      end
    end
    for (int j = 0; j < int'(COL); j++) begin
      bus.in_valid = 1'b1; bus.in_data = row(2, j);
      @(negedge clk);
      chk($sformatf("kwr_inst%0d", j), 64'(bus.inst), 64'(iw(0, j, 0, 0, 0, 0, 0, 0, 1, 0)));
      chk($sformatf("kwr_mem%0d", j), bus.mem_in, row(2, j));
    end
    // start raised while busy must not restart or relatch the row count
    bus.in_valid = 1'b1; bus.in_data = row(9, 99); bus.start = 1'b1; bus.q_rows_m1 = 4'd7;
    for (int k = 0; k <= int'(COL); k++) begin
      @(negedge clk);
      chk($sformatf("kfeed_inst%0d", k), 64'(bus.inst),
          64'(iw(0, (k < int'(COL)) ? k : 0, 0, 0, k >= 1, 0, 0, k < int'(COL), 0, 0)));
      chk($sformatf("kfeed_ready%0d", k), 64'(bus.in_ready), 0);
    end
    bus.start = 1'b0; bus.q_rows_m1 = 4'd0; bus.in_valid = 1'b0;
    for (int n = 0; n <= nq; n++) begin
      @(negedge clk);
      chk($sformatf("exec_inst%0d", n), 64'(bus.inst),
          64'(iw(0, (n < nq) ? n : 0, 0, n >= 1, 0, n < nq, 0, 0, 0, 0)));
    end
    chk("exec_mem_hold", bus.mem_in, row(2, COL - 1));
    for (int d = 0; d < fdelay; d++) begin
      @(negedge clk);
      chk($sformatf("drain_wait_inst%0d", d), 64'(bus.inst), 0);
      chk($sformatf("drain_wait_busy%0d", d), 64'(bus.busy), 1);
    end
    bus.fifo_valid = 1'b1;
    for (int p = 0; p < nq; p++) begin
      @(negedge clk);
      chk($sformatf("pwr_inst%0d", p), 64'(bus.inst), 64'(iw(1, 0, p, 0, 0, 0, 0, 0, 0, 1)));
      chk($sformatf("pwr_done%0d", p), 64'(bus.done), 0);
    end
    @(negedge clk);
    chk("fin_inst", 64'(bus.inst), 0);
    chk("fin_done", 64'(bus.done), 1);
    chk("fin_busy", 64'(bus.busy), 0);
    bus.fifo_valid = 1'b0;
    @(negedge clk);
    chk("post_done", 64'(bus.done), 0);
    chk("post_inst", 64'(bus.inst), 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.q_rows_m1 = 4'd0; bus.in_data = '0;
    bus.in_valid = 1'b0; bus.fifo_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_inst", 64'(bus.inst), 0);
    chk("rst_busy", 64'(bus.busy), 0);
    chk("rst_ready", 64'(bus.in_ready), 0);
    chk("rst_done", 64'(bus.done), 0);
    chk("rst_mem", bus.mem_in, 0);
    reset = 1'b0;

    // start together with reset: reset wins
    @(negedge clk);
    bus.start = 1'b1; reset = 1'b1;
    @(negedge clk);
    chk("start_rst_busy", 64'(bus.busy), 0);
    bus.start = 1'b0; reset = 1'b0;
    @(negedge clk);
    chk("start_rst_idle", 64'(bus.busy), 0);

    // basic tile, in_valid held high, fifo always ready
    run_tile(3, 1'b0, 0);
    // gapped Q handshake plus stalled drain
    run_tile(3, 1'b1, 10);

    // reset at KFEED cycle 3
    @(negedge clk);
    bus.start = 1'b1; bus.q_rows_m1 = 4'd1;
    @(negedge clk);
    bus.start = 1'b0; bus.in_valid = 1'b1;
    for (int i = 0; i < 2 + int'(COL); i++) begin
      bus.in_data = row(3, i);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("kfeed3_pre_inst", 64'(bus.inst), 64'(iw(0, 2, 0, 0, 1, 0, 0, 1, 0, 0)));
    #2 reset = 1'b1;
    #1;
    chk("abort_inst", 64'(bus.inst), 0);
    chk("abort_busy", 64'(bus.busy), 0);
    chk("abort_ready", 64'(bus.in_ready), 0);
    @(negedge clk);
    chk("abort_hold_inst", 64'(bus.inst), 0);
    reset = 1'b0;

    // clean tile after abort, then maximum row count
    run_tile(0, 1'b0, 2);
    run_tile(15, 1'b0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
